output_layer: RTL and testbench

- Final ANN stage, directly downstream of the two-neuron hidden layer.
- Consumes the hidden layer's serial stream of 32-bit Q16.16 activations, one beat per valid strobe.
- Computes N_OUT fully-connected output neurons with saturating fixed-point MAC, bias and ReLU.
- Produces the winning class index (argmax) and its value with a one-cycle done pulse.

---
 rtl/output_layer.sv | 160 ++++++++++++++++
 tb/tb_output_layer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/output_layer.sv
// Output layer of the ANN: accumulates N_IN serial Q16.16 beats into N_OUT saturating
// MAC neurons, applies bias and ReLU, then scans for the winning class.
//
// state | meaning
// IDLE  | waiting for beat 0 of a frame
// ACC   | accumulating beats 1..N_IN-1
// FIN   | add bias, apply ReLU, arm the argmax scan
// CMP   | compare one neuron per cycle against the running best
// OUT   | publish winner and pulse done
module output_layer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int IDX_W = 1,
    parameter logic [N_OUT*N_IN*32-1:0] WEIGHTS =
        {32'h00030000, 32'hFFFF0000, 32'h00020000, 32'h00010000},
    parameter logic [N_OUT*32-1:0] BIASES = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out,
    output logic [IDX_W-1:0] class_idx,
    output logic             done
);

    localparam int BI_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int KW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC  = 3'd1;
    localparam logic [2:0] S_FIN  = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic signed [31:0] Q_MAX = 32'sh7FFFFFFF;
    localparam logic signed [31:0] Q_MIN = 32'sh80000000;

    function automatic logic signed [31:0] sat_mul(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        logic signed [63:0] p;
        p = a * b;
        // result must fit in 48 signed bits before dropping the 16 fraction bits
        if (p[63:47] == {17{p[47]}})
            sat_mul = p[47:16];
        else
            sat_mul = p[63] ? Q_MIN : Q_MAX;
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            sat_add = s[32] ? Q_MIN : Q_MAX;
        else
            sat_add = s[31:0];
    endfunction

    function automatic logic signed [31:0] relu(input logic signed [31:0] x);
        relu = x[31] ? 32'sd0 : x;
    endfunction

    logic [2:0]             state;
    logic [BI_W-1:0]        cnt;
    logic [KW-1:0]          k;
    logic signed [31:0]     acc [N_OUT];
    logic signed [31:0]     best_val;
    logic [IDX_W-1:0]       best_idx;

    logic signed [31:0]     w_tab [N_OUT][N_IN];
    logic signed [31:0]     b_tab [N_OUT];
    logic signed [31:0]     term  [N_OUT];

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        for (genvar i = 0; i < N_IN; i++) begin : g_beat
            assign w_tab[j][i] = WEIGHTS[(j*N_IN+i)*32 +: 32];
        end
        assign b_tab[j] = BIASES[j*32 +: 32];
    end

    // cnt is held at 0 outside a frame, so IDLE picks column 0 of the weights
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            term[j] = sat_mul($signed(in_data), w_tab[j][cnt]);
        end
    end

    assign in_ready = (state == S_IDLE) || (state == S_ACC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            k         <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            out       <= '0;
            class_idx <= '0;
            done      <= 1'b0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < N_OUT; j++) acc[j] <= term[j];
                        if (N_IN == 1) begin
                            cnt   <= '0;
                            state <= S_FIN;
                        end else begin
                            cnt   <= BI_W'(1);
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        for (int j = 0; j < N_OUT; j++) acc[j] <= sat_add(acc[j], term[j]);
                        if (cnt == BI_W'(N_IN - 1)) begin
                            cnt   <= '0;
                            state <= S_FIN;
                        end else begin
                            cnt <= cnt + BI_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    for (int j = 0; j < N_OUT; j++) acc[j] <= relu(sat_add(acc[j], b_tab[j]));
                    best_val <= Q_MIN;
                    best_idx <= '0;
                    k        <= '0;
                    state    <= S_CMP;
                end
                S_CMP: begin
                    // strict compare keeps the lower index on ties
                    if (acc[k] > best_val) begin
                        best_val <= acc[k];
                        best_idx <= IDX_W'(k);
                    end
                    if (k == KW'(N_OUT - 1)) begin
                        k     <= '0;
                        state <= S_OUT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_OUT: begin
                    out       <= best_val;
                    class_idx <= best_idx;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer.sv
// Bench for output_layer: directed frames plus randomized frames checked against a
// plain-arithmetic model of the two-neuron output layer.
module tb_output_layer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out;
    logic [0:0]  class_idx;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    // w_m[j][i]: neuron j, beat i (1.0, 2.0 / -1.0, 3.0), biases zero
    logic [31:0] w_m [2][2] = '{'{32'h00010000, 32'h00020000},
                                '{32'hFFFF0000, 32'h00030000}};

    always #5 clk = ~clk;

    output_layer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .class_idx (class_idx),
        .done      (done)
    );

    function automatic longint clamp32(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic void model(input logic [31:0] x0, input logic [31:0] x1,
                                  output logic [31:0] eo, output logic [0:0] ei);
        logic [31:0] xs [2];
        longint a, best, p;
        xs[0] = x0;
        xs[1] = x1;
        best  = MINV;
        ei    = 1'b0;
        for (int j = 0; j < 2; j++) begin
            a = 0;
            for (int i = 0; i < 2; i++) begin
                p = longint'($signed(xs[i])) * longint'($signed(w_m[j][i]));
                a = clamp32(a + clamp32(p >>> 16));
            end
            if (a < 0) a = 0;
            if (a > best) begin
                best = a;
                ei   = 1'(j);
            end
        end
        eo = best[31:0];
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] edge_vals [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h7FFF0000};
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 32'h00100000)) - 32'h00080000;
            default: return edge_vals[$urandom_range(0, 3)];
        endcase
    endfunction

    // Called at a negedge; the beat is taken on the following posedge.
    task automatic send_beat(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_beats(input logic [31:0] b0, input logic [31:0] b1, input int gap);
        send_beat(b0);
        repeat (gap) @(negedge clk);
        send_beat(b1);
    endtask

    task automatic wait_done(output logic [31:0] o, output logic [0:0] ci, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 20);
        o  = out;
        ci = class_idx;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = c[0];
            in_data  = 32'h00010000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h expected %h", out, 32'h0); end
        n_cmp++; if (class_idx !== 1'b0) begin n_err++; $display("FAIL reset_idx: got %h expected 0", class_idx); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] b0 [5] = '{32'h00010000, 32'h00020000, 32'h0,        32'h00010000, 32'h7FFF0000};
        logic [31:0] b1 [5] = '{32'h00010000, 32'h0,        32'h00010000, 32'h00020000, 32'h7FFF0000};
        int          gp [5] = '{0, 0, 0, 3, 0};
        logic [31:0] eo [5] = '{32'h00030000, 32'h00020000, 32'h00030000, 32'h00050000, 32'h7FFFFFFF};
        logic [0:0]  ei [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] o;
        logic [0:0]  ci;
        int          lat;
        for (int t = 0; t < 5; t++) begin
            run_beats(b0[t], b1[t], gp[t]);
            wait_done(o, ci, lat);
            // lat counts negedges after the accepting edge: done is seen after its 5th edge
            n_cmp++; if (lat != 4) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected 4", t, lat); end
            n_cmp++; if (o !== eo[t]) begin n_err++; $display("FAIL dir%0d_out: got %h expected %h", t, o, eo[t]); end
            n_cmp++; if (ci !== ei[t]) begin n_err++; $display("FAIL dir%0d_idx: got %h expected %h", t, ci, ei[t]); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_pulse: got %b expected 0", t, done); end
            n_cmp++; if (out !== eo[t]) begin n_err++; $display("FAIL dir%0d_hold: got %h expected %h", t, out, eo[t]); end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] o;
        logic [0:0]  ci;
        int          lat;
        send_beat(32'h00050000);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_cmp++; if (out !== 32'h0) begin n_err++; $display("FAIL midrst_out_clr: got %h expected 0", out); end
        run_beats(32'h0, 32'h00010000, 0);
        wait_done(o, ci, lat);
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
        n_cmp++; if (o !== 32'h00030000) begin n_err++; $display("FAIL midrst_out: got %h expected %h", o, 32'h00030000); end
        n_cmp++; if (ci !== 1'b1) begin n_err++; $display("FAIL midrst_idx: got %h expected 1", ci); end
        @(negedge clk);
    endtask

    task automatic test_dropped();
        logic [31:0] a, b, o, eo;
        logic [0:0]  ci, ei;
        int          lat;
        a = rnd_val();
        b = rnd_val();
        model(a, b, eo, ei);
        run_beats(a, b, 0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL drop_ready_fin: got %b expected 0", in_ready); end
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = $urandom;
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL drop_ready_%0d: got %b expected 0", c, in_ready); end
        end
        in_valid = 1'b0;
        wait_done(o, ci, lat);
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL drop_latency: got %0d expected 1", lat); end
        n_cmp++; if (o !== eo) begin n_err++; $display("FAIL drop_out: got %h expected %h", o, eo); end
        n_cmp++; if (ci !== ei) begin n_err++; $display("FAIL drop_idx: got %h expected %h", ci, ei); end
        @(negedge clk);
    endtask

    // Random frames; some start on the very cycle done is seen (back to back).
    task automatic test_random();
        logic [31:0] a, b, o, eo;
        logic [0:0]  ci, ei;
        int          lat;
        for (int t = 0; t < 40; t++) begin
            a = rnd_val();
            b = rnd_val();
            model(a, b, eo, ei);
            run_beats(a, b, $urandom_range(0, 2));
            wait_done(o, ci, lat);
            n_cmp++; if (lat != 4) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected 4", t, lat); end
            n_cmp++; if (o !== eo) begin n_err++; $display("FAIL rnd%0d_out: in %h %h got %h expected %h", t, a, b, o, eo); end
            n_cmp++; if (ci !== ei) begin n_err++; $display("FAIL rnd%0d_idx: in %h %h got %h expected %h", t, a, b, ci, ei); end
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rnd%0d_pulse: got %b expected 0", t, done); end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_mid_reset();
        test_dropped();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
